// File: rtl/bus_pkg.sv
// Shared definitions for the AXI4-Lite bus master.
// Contents: FSM state encoding, AXI response codes, request mode encoding,
// and the data word returned when a transaction is aborted on timeout.
package bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP,
    S_RESPOND
  } bus_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/axi_lite_bus_master_if.sv
// Bundle of the client request/response strobes and the five AXI4-Lite
// channels seen by the bus master.
// Modports:
//   master - the bus master itself (takes requests, drives AXI address/data)
//   slave  - its environment (request client plus memory interconnect)
interface axi_lite_bus_master_if;

  // client side
  logic        request_enable;
  logic        mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        response_enable;
  logic [31:0] data;
  logic        resp_err;
  logic        busy;
  logic        protocol_err;

  // AXI4-Lite side
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [2:0]  m_arprot;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [2:0]  m_awprot;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;

  modport master (
    input  request_enable, mode, addr, wdata, wstrb,
           m_arready, m_rdata, m_rresp, m_rvalid,
           m_awready, m_wready, m_bresp, m_bvalid,
    output response_enable, data, resp_err, busy, protocol_err,
           m_araddr, m_arvalid, m_arprot, m_rready,
           m_awaddr, m_awvalid, m_awprot, m_wdata, m_wstrb, m_wvalid, m_bready
  );

  modport slave (
    output request_enable, mode, addr, wdata, wstrb,
           m_arready, m_rdata, m_rresp, m_rvalid,
           m_awready, m_wready, m_bresp, m_bvalid,
    input  response_enable, data, resp_err, busy, protocol_err,
           m_araddr, m_arvalid, m_arprot, m_rready,
           m_awaddr, m_awvalid, m_awprot, m_wdata, m_wstrb, m_wvalid, m_bready
  );

endinterface

// File: rtl/axi_lite_bus_master.sv
// Single-outstanding request/response to AXI4-Lite master bridge.
// A one-cycle request strobe launches one AXI read or write; completion is
// reported with a one-cycle response_enable pulse carrying read data and an
// error flag.
// Ports:
//   clk  - system clock
//   rstn - asynchronous active-low reset
//   bus  - axi_lite_bus_master_if.master (client strobes + AXI channels)
// Parameters:
//   TIMEOUT_CYCLES - per-transaction cycle limit (timeout build only)
//   PROT           - constant driven on m_arprot/m_awprot
// Build option:
//   AXI_BUS_TIMEOUT_EN - when defined, a stuck transaction is aborted after
//   TIMEOUT_CYCLES busy cycles and answered with TIMEOUT_DATA / resp_err=1.
//
// state     | meaning
// ----------+------------------------------------------------------
// S_IDLE    | waiting for request_enable
// S_RD_ADDR | m_arvalid held until m_arready
// S_RD_DATA | m_rready high, waiting for m_rvalid
// S_WR_REQ  | AW and W valids, each dropped after its own handshake
// S_WR_RESP | m_bready high, waiting for m_bvalid
// S_RESPOND | one-cycle response_enable, busy already low
module axi_lite_bus_master
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [2:0]  PROT           = 3'b000
) (
  input logic                   clk,
  input logic                   rstn,
  axi_lite_bus_master_if.master bus
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  bus_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] data_q, data_d;
  logic        resp_err_q, resp_err_d;
  logic        protocol_err_q, protocol_err_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        busy;
  logic        aw_ok, w_ok;

`ifdef AXI_BUS_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic        unused_tmo;
  assign unused_tmo = ^TMO_LAST;
`endif

  assign busy = state_q inside {S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP};

  // a write channel counts as done once its valid has been accepted
  assign aw_ok = !awvalid_q || bus.m_awready;
  assign w_ok  = !wvalid_q  || bus.m_wready;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    data_d         = data_q;
    resp_err_d     = resp_err_q;
    arvalid_d      = arvalid_q;
    rready_d       = rready_q;
    awvalid_d      = awvalid_q;
    wvalid_d       = wvalid_q;
    bready_d       = bready_q;
    protocol_err_d = protocol_err_q | (bus.request_enable && (state_q != S_IDLE));

    unique case (state_q)
      S_IDLE: begin
        if (bus.request_enable) begin
          addr_d   = bus.addr;
          wdata_d  = bus.wdata;
          wstrb_d  = bus.wstrb;
          // a drain ready left over from an aborted transaction ends here
          rready_d = 1'b0;
          bready_d = 1'b0;
          if (bus.mode == MODE_WRITE) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_ADDR;
          end
        end
      end
      S_RD_ADDR: begin
        if (bus.m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (bus.m_rvalid) begin
          data_d     = bus.m_rdata;
          resp_err_d = (bus.m_rresp != RESP_OKAY);
          rready_d   = 1'b0;
          state_d    = S_RESPOND;
        end
      end
      S_WR_REQ: begin
        if (awvalid_q && bus.m_awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.m_wready)   wvalid_d  = 1'b0;
        if (aw_ok && w_ok) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (bus.m_bvalid) begin
          data_d     = '0;
          resp_err_d = (bus.m_bresp != RESP_OKAY);
          bready_d   = 1'b0;
          state_d    = S_RESPOND;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

`ifdef AXI_BUS_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    // late beats of an aborted transaction are swallowed while idle
    if (state_q inside {S_IDLE, S_RESPOND}) begin
      if (rready_q && bus.m_rvalid) rready_d = 1'b0;
      if (bready_q && bus.m_bvalid) bready_d = 1'b0;
    end
    if (state_q == S_IDLE && bus.request_enable) begin
      tmo_cnt_d = '0;
    end else if (busy) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
      // a transaction finishing on the last allowed cycle is not aborted;
      // any ready already raised stays high to absorb the late beat
      if (tmo_cnt_q == TMO_LAST && state_d != S_RESPOND) begin
        arvalid_d  = 1'b0;
        awvalid_d  = 1'b0;
        wvalid_d   = 1'b0;
        data_d     = TIMEOUT_DATA;
        resp_err_d = 1'b1;
        state_d    = S_RESPOND;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      data_q         <= '0;
      resp_err_q     <= 1'b0;
      protocol_err_q <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      data_q         <= data_d;
      resp_err_q     <= resp_err_d;
      protocol_err_q <= protocol_err_d;
      arvalid_q      <= arvalid_d;
      rready_q       <= rready_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      bready_q       <= bready_d;
    end
  end

`ifdef AXI_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign bus.busy            = busy;
  assign bus.response_enable = (state_q == S_RESPOND);
  assign bus.data            = data_q;
  assign bus.resp_err        = resp_err_q;
  assign bus.protocol_err    = protocol_err_q;
  assign bus.m_araddr        = addr_q;
  assign bus.m_arvalid       = arvalid_q;
  assign bus.m_arprot        = PROT;
  assign bus.m_rready        = rready_q;
  assign bus.m_awaddr        = addr_q;
  assign bus.m_awvalid       = awvalid_q;
  assign bus.m_awprot        = PROT;
  assign bus.m_wdata         = wdata_q;
  assign bus.m_wstrb         = wstrb_q;
  assign bus.m_wvalid        = wvalid_q;
  assign bus.m_bready        = bready_q;

endmodule
